// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RELEASE  = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } rst_seq_state_e;

    localparam int unsigned DEF_NUM_STAGES  = 3;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_ACK_TIMEOUT = 64;

    // Larger of two unsigned values, used for counter sizing.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES clk edges.
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] chain_q;

    // Shift ones in from the bottom; rst_n clears the whole chain at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases per-subsystem resets in index order, each gated by an ack.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sw_rst_req,
    input  logic [NUM_STAGES-1:0]             stage_ack,
    output logic [NUM_STAGES-1:0]             stage_rst_n,
    output logic                              rst_done,
    output logic                              timeout_err,
    output logic [$clog2(NUM_STAGES+1)-1:0]   cur_stage
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, ACK_TIMEOUT));
    localparam int unsigned CS_W  = $clog2(NUM_STAGES + 1);

    logic                  rst_sync_n;
    rst_seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_rst_n_d;
    logic                  rst_done_d;
    logic                  timeout_err_d;
    logic [CS_W-1:0]       cur_stage_d;
    logic [NUM_STAGES-1:0] cur_mask;
    logic                  ack_sel;
    logic                  hold_end;
    logic                  ack_expired;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    // One-hot select of the stage currently being released.
    assign cur_mask    = NUM_STAGES'(1) << cur_stage;
    assign ack_sel     = |(stage_ack & cur_mask);
    assign hold_end    = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign ack_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    // State and output registers, cleared by the synchronised reset.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            stage_rst_n <= '0;
            rst_done    <= 1'b0;
            timeout_err <= 1'b0;
            cur_stage   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_rst_n <= stage_rst_n_d;
            rst_done    <= rst_done_d;
            timeout_err <= timeout_err_d;
            cur_stage   <= cur_stage_d;
        end
    end

    // Next-state and next-output logic; software reset overrides everything but the sticky error.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_rst_n_d = stage_rst_n;
        rst_done_d    = rst_done;
        timeout_err_d = timeout_err;
        cur_stage_d   = cur_stage;

        if (sw_rst_req) begin
            state_d       = HOLD;
            cnt_d         = '0;
            stage_rst_n_d = '0;
            rst_done_d    = 1'b0;
            cur_stage_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_end) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    stage_rst_n_d = stage_rst_n | cur_mask;
                    state_d       = WAIT_ACK;
                    cnt_d         = '0;
                end
                WAIT_ACK: begin
                    if (ack_sel || ack_expired) begin
                        if (!ack_sel) begin
                            timeout_err_d = 1'b1;
                        end
                        cnt_d = '0;
                        if (cur_stage == CS_W'(NUM_STAGES - 1)) begin
                            state_d     = DONE;
                            cur_stage_d = CS_W'(NUM_STAGES);
                            rst_done_d  = 1'b1;
                        end else begin
                            state_d     = RELEASE;
                            cur_stage_d = cur_stage + CS_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    rst_done_d = 1'b1;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq against a release-schedule model.
module tb_rst_seq;

    localparam int unsigned N    = 3;
    localparam int unsigned SYNC = 2;
    localparam int unsigned HOLD = 16;
    localparam int unsigned TMO  = 64;
    localparam int          NEVER = 1000;

    logic         clk;
    logic         rst_n;
    logic         sw_rst_req;
    logic [N-1:0] stage_ack;
    logic [N-1:0] stage_rst_n;
    logic         rst_done;
    logic         timeout_err;
    logic [1:0]   cur_stage;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    bit clk_en = 1'b1;

    // Model: per-stage ack behaviour and the resulting schedule of edges.
    int d_ack [N];
    bit tied  [N];
    int r_e   [N];
    int a_e   [N];
    bit to_f  [N];
    int done_e;
    bit te_prev;

    rst_seq #(
        .NUM_STAGES  (N),
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .stage_ack   (stage_ack),
        .stage_rst_n (stage_rst_n),
        .rst_done    (rst_done),
        .timeout_err (timeout_err),
        .cur_stage   (cur_stage)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Build the release schedule for a sequence whose hold count starts at edge s.
    task automatic plan(input int s);
        int t;
        int k;
        t = s + int'(HOLD) + 1;
        for (int i = 0; i < int'(N); i++) begin
            r_e[i] = t;
            if (tied[i])                    k = 1;
            else if (d_ack[i] + 1 <= int'(TMO)) k = d_ack[i] + 1;
            else                            k = int'(TMO);
            to_f[i] = !tied[i] && (d_ack[i] + 1 > int'(TMO));
            a_e[i]  = t + k;
            t       = a_e[i] + 1;
        end
        done_e = a_e[N-1];
    endtask

    // Drive acks from the model, optionally pulse sw_rst_req at sw_at, compare every edge.
    task automatic run_and_compare(input int until_e, input int sw_at);
        logic [N-1:0] exp_srn;
        logic [1:0]   exp_cs;
        logic         exp_done;
        logic         exp_te;
        int           lim;
        int           ncs;
        while (edge_n < until_e) begin
            for (int i = 0; i < int'(N); i++)
                stage_ack[i] = tied[i] || (edge_n + 1 >= r_e[i] + 1 + d_ack[i]);
            sw_rst_req = (edge_n + 1 == sw_at);
            step();
            sw_rst_req = 1'b0;
            lim    = (sw_at != 0 && edge_n >= sw_at) ? sw_at - 1 : edge_n;
            exp_te = te_prev;
            for (int i = 0; i < int'(N); i++)
                if (to_f[i] && a_e[i] <= lim) exp_te = 1'b1;
            if (sw_at != 0 && edge_n >= sw_at) begin
                exp_srn  = '0;
                exp_cs   = '0;
                exp_done = 1'b0;
            end else begin
                ncs = 0;
                for (int i = 0; i < int'(N); i++) begin
                    exp_srn[i] = (edge_n >= r_e[i]);
                    if (a_e[i] <= edge_n) ncs++;
                end
                exp_cs   = 2'(ncs);
                exp_done = (edge_n >= done_e);
            end
            checks += 4;
            if (stage_rst_n !== exp_srn) begin
                errors++;
                $display("FAIL stage_rst_n edge=%0d got=%b exp=%b", edge_n, stage_rst_n, exp_srn);
            end
            if (cur_stage !== exp_cs) begin
                errors++;
                $display("FAIL cur_stage edge=%0d got=%0d exp=%0d", edge_n, cur_stage, exp_cs);
            end
            if (rst_done !== exp_done) begin
                errors++;
                $display("FAIL rst_done edge=%0d got=%b exp=%b", edge_n, rst_done, exp_done);
            end
            if (timeout_err !== exp_te) begin
                errors++;
                $display("FAIL timeout_err edge=%0d got=%b exp=%b", edge_n, timeout_err, exp_te);
            end
        end
    endtask

    // Pulse sw_rst_req so it is sampled at edge s, then fold finished timeouts into the sticky model.
    task automatic sw_restart(input int s);
        run_and_compare(s, s);
        for (int i = 0; i < int'(N); i++)
            if (to_f[i] && a_e[i] < s) te_prev = 1'b1;
    endtask

    task automatic set_acks(input bit t0, input bit t1, input bit t2,
                            input int d0, input int d1, input int d2);
        tied[0] = t0; tied[1] = t1; tied[2] = t2;
        d_ack[0] = d0; d_ack[1] = d1; d_ack[2] = d2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw_rst_req = 1'b0; stage_ack = '1;
        set_acks(1'b1, 1'b1, 1'b1, 0, 0, 0);
        repeat (4) step();
        checks += 3;
        if (stage_rst_n !== 3'b000) begin
            errors++; $display("FAIL reset_stage_rst_n got=%b exp=000", stage_rst_n);
        end
        if (rst_done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b exp=00", rst_done, timeout_err);
        end
        if (cur_stage !== 2'd0) begin
            errors++; $display("FAIL reset_cur_stage got=%0d exp=0", cur_stage);
        end
    endtask

    // Release rst_n just after an edge so the next posedge counts as edge 1.
    task automatic test_power_on();
        rst_n   = 1'b1;
        edge_n  = 0;
        te_prev = 1'b0;
        plan(SYNC);
        run_and_compare(done_e + 3, 0);
    endtask

    task automatic test_timeout();
        int s;
        s = edge_n + 1;
        sw_restart(s);
        set_acks(1'b0, 1'b0, 1'b0, 0, NEVER, 2);
        plan(s);
        run_and_compare(done_e + 3, 0);
    endtask

    task automatic test_async_drop();
        int s;
        s = edge_n + 1;
        sw_restart(s);
        set_acks(1'b0, 1'b0, 1'b0, 0, 30, 0);
        plan(s);
        run_and_compare(r_e[1] + 5, 0);
        clk_en = 1'b0;
        #7;
        rst_n = 1'b0;
        #3;
        checks += 3;
        if (stage_rst_n !== 3'b000) begin
            errors++; $display("FAIL async_stage_rst_n got=%b exp=000", stage_rst_n);
        end
        if (timeout_err !== 1'b0 || rst_done !== 1'b0) begin
            errors++; $display("FAIL async_flags got=%b%b exp=00", timeout_err, rst_done);
        end
        if (cur_stage !== 2'd0) begin
            errors++; $display("FAIL async_cur_stage got=%0d exp=0", cur_stage);
        end
        #20;
        rst_n   = 1'b1;
        edge_n  = 0;
        te_prev = 1'b0;
        set_acks(1'b1, 1'b0, 1'b1, 0, 4, 0);
        plan(SYNC);
        clk_en = 1'b1;
        run_and_compare(done_e + 3, 0);
    endtask

    task automatic test_wrong_ack();
        int s;
        s = edge_n + 1;
        sw_restart(s);
        set_acks(1'b0, 1'b0, 1'b1, 70, 10, 0);
        plan(s);
        run_and_compare(done_e + 3, 0);
    endtask

    task automatic test_sw_vs_ack();
        int s;
        s = edge_n + 1;
        sw_restart(s);
        set_acks(1'b1, 1'b1, 1'b1, 0, 0, 0);
        plan(s);
        s = a_e[1];
        sw_restart(s);
        plan(s);
        run_and_compare(done_e + 3, 0);
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 8; n++) begin
            s = edge_n + 1;
            sw_restart(s);
            for (int i = 0; i < int'(N); i++) begin
                tied[i]  = ($urandom_range(0, 3) == 0);
                d_ack[i] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 70));
            end
            plan(s);
            if ($urandom_range(0, 2) == 0) begin
                s = edge_n + 1 + int'($urandom_range(0, 32'(done_e - edge_n - 1)));
                sw_restart(s);
                plan(s);
            end
            run_and_compare(done_e + int'($urandom_range(2, 5)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_timeout();
        test_async_drop();
        test_wrong_ack();
        test_sw_vs_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
